// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
//
// Writeback arbiter for the register status table and register file. NREQ
// functional-unit result ports compete for one writeback slot per cycle. One
// live result is granted per cycle with round-robin fairness and is registered
// into a one-entry output stage that holds while wb_stall is high. Results that
// target r0, and speculative results killed by a branch flush, are accepted
// and dropped without using the writeback slot.
//
// Ports
//   CLK        clock
//   RST        synchronous active-high reset
//   req_valid  [NREQ]          result pending, one bit per requester
//   req_ready  [NREQ]          result accepted this cycle (combinational)
//   req_sel    [NREQ*REG_W]    destination register per requester
//   req_tag    [NREQ*TAG_W]    status-table tag per requester
//   req_data   [NREQ*DATA_W]   result value per requester
//   req_spec   [NREQ]          result is under an unresolved branch
//   flush      mispredict: kill all speculative work
//   resolved   branch resolved correct: clear speculation
//   wb_stall   consumer cannot take the output this cycle
//   wb_write   writeback valid
//   wb_sel     writeback register
//   wb_tag     writeback tag
//   wb_data    writeback value
//   wb_spec    output entry is speculative
// -----------------------------------------------------------------------------
module wb_arbiter #(
    parameter int NREQ   = 4,
    parameter int REG_W  = 5,
    parameter int TAG_W  = 3,
    parameter int DATA_W = 32
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*REG_W-1:0]    req_sel,
    input  logic [NREQ*TAG_W-1:0]    req_tag,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    input  logic [NREQ-1:0]          req_spec,
    input  logic                     flush,
    input  logic                     resolved,
    input  logic                     wb_stall,
    output logic                     wb_write,
    output logic [REG_W-1:0]         wb_sel,
    output logic [TAG_W-1:0]         wb_tag,
    output logic [DATA_W-1:0]        wb_data,
    output logic                     wb_spec
);

    localparam int PTR_W = $clog2(NREQ);

    // Output stage and round-robin pointer
    logic              out_v;
    logic [REG_W-1:0]  out_sel;
    logic [TAG_W-1:0]  out_tag;
    logic [DATA_W-1:0] out_data;
    logic              out_spec;
    logic [PTR_W-1:0]  ptr;

    // Arbitration results
    logic              load_ok;
    logic [NREQ-1:0]   dead;
    logic [NREQ-1:0]   grant;
    logic              gnt_found;
    logic [PTR_W-1:0]  gnt_idx;
    logic [REG_W-1:0]  gnt_sel;
    logic [TAG_W-1:0]  gnt_tag;
    logic [DATA_W-1:0] gnt_data;
    logic              gnt_spec;
    logic [PTR_W-1:0]  ptr_next;

    always_comb begin
        int idx;
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        load_ok   = ~out_v | ~wb_stall;
        dead      = '0;
        grant     = '0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        gnt_sel   = '0;
        gnt_tag   = '0;
        gnt_data  = '0;
        gnt_spec  = 1'b0;
        idx       = 0;

        // Dead results are acknowledged and dropped regardless of stall.
        for (int i = 0; i < NREQ; i++) begin
            dead[i] = req_valid[i] &
                      ((req_sel[i*REG_W +: REG_W] == '0) | (flush & req_spec[i]));
        end

        // Scan ptr, ptr+1, ... modulo NREQ; first live requester wins.
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (load_ok && !gnt_found && req_valid[idx] && !dead[idx]) begin
                gnt_found  = 1'b1;
                grant[idx] = 1'b1;
                gnt_idx    = PTR_W'(idx);
                gnt_sel    = req_sel[idx*REG_W +: REG_W];
                gnt_tag    = req_tag[idx*TAG_W +: TAG_W];
                gnt_data   = req_data[idx*DATA_W +: DATA_W];
                gnt_spec   = req_spec[idx];
            end
        end

        // Explicit wrap keeps the pointer in range for non-power-of-2 NREQ.
        ptr_next = (gnt_idx == PTR_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

        req_ready = RST ? '0 : (dead | grant);
    end

    always_ff @(posedge CLK) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (RST) begin
            // NOTE: the payload registers are reset too, not just the valid
            // bit, because the wb_* outputs must read zero after reset.
            out_v    <= 1'b0;
            out_sel  <= '0;
            out_tag  <= '0;
            out_data <= '0;
            out_spec <= 1'b0;
            ptr      <= '0;
        end else if (gnt_found) begin
            out_v    <= 1'b1;
            out_sel  <= gnt_sel;
            out_tag  <= gnt_tag;
            out_data <= gnt_data;
            out_spec <= gnt_spec & ~resolved;
            ptr      <= ptr_next;
        end else if (load_ok) begin
            out_v <= 1'b0;
        end else begin
            // Held entry: flush beats resolved for a speculative entry.
            if (flush && out_spec) begin
                out_v <= 1'b0;
            end else if (resolved) begin
                out_spec <= 1'b0;
            end
        end
    end

    // A speculative entry is masked in the very cycle the flush arrives.
    assign wb_write = out_v & ~(flush & out_spec);
    assign wb_sel   = out_sel;
    assign wb_tag   = out_tag;
    assign wb_data  = out_data;
    assign wb_spec  = out_spec;

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
//
// Drives wb_arbiter with directed scenarios and randomized traffic. A
// behavioural reference model (round-robin scan over an array, modulo pointer,
// one-entry output record) predicts req_ready and the wb_* outputs each cycle.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;

    localparam int N  = 4;
    localparam int RW = 5;
    localparam int TW = 3;
    localparam int DW = 32;

    logic            CLK;
    logic            RST;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*RW-1:0] req_sel_f;
    logic [N*TW-1:0] req_tag_f;
    logic [N*DW-1:0] req_data_f;
    logic [N-1:0]    req_spec;
    logic            flush;
    logic            resolved;
    logic            wb_stall;
    logic            wb_write;
    logic [RW-1:0]   wb_sel;
    logic [TW-1:0]   wb_tag;
    logic [DW-1:0]   wb_data;
    logic            wb_spec;

    // Per-requester payloads, packed into the flat ports below
    logic [RW-1:0] sel  [N];
    logic [TW-1:0] tag  [N];
    logic [DW-1:0] data [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_sel_f[i*RW +: RW]  = sel[i];
            req_tag_f[i*TW +: TW]  = tag[i];
            req_data_f[i*DW +: DW] = data[i];
        end
    end

    wb_arbiter #(.NREQ(N), .REG_W(RW), .TAG_W(TW), .DATA_W(DW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_sel   (req_sel_f),
        .req_tag   (req_tag_f),
        .req_data  (req_data_f),
        .req_spec  (req_spec),
        .flush     (flush),
        .resolved  (resolved),
        .wb_stall  (wb_stall),
        .wb_write  (wb_write),
        .wb_sel    (wb_sel),
        .wb_tag    (wb_tag),
        .wb_data   (wb_data),
        .wb_spec   (wb_spec)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // Reference model: the single writeback record and the next-scan start
    bit            m_v;
    bit            m_spec;
    logic [RW-1:0] m_sel;
    logic [TW-1:0] m_tag;
    logic [DW-1:0] m_data;
    int            m_ptr;
    logic [N-1:0]  last_ready;

    task automatic model_reset();
        m_v = 0; m_spec = 0; m_sel = '0; m_tag = '0; m_data = '0; m_ptr = 0;
        last_ready = '0;
    endtask

    task automatic clear_inputs();
        req_valid = '0; req_spec = '0; flush = 0; resolved = 0; wb_stall = 0;
        for (int i = 0; i < N; i++) begin
            sel[i] = '0; tag[i] = '0; data[i] = '0;
        end
    endtask

    // One clock cycle. Called just after a rising edge with inputs set;
    // compares at the falling edge, then advances the model at the next edge.
    task automatic cycle();
        logic [N-1:0] exp_ready;
        bit           is_dead [N];
        bit           can_load;
        bit           exp_w;
        int           g;
        exp_ready = '0;
        g         = -1;
        can_load  = !m_v || !wb_stall;
        for (int i = 0; i < N; i++)
            is_dead[i] = req_valid[i] && (sel[i] == 0 || (flush && req_spec[i]));
        if (!RST) begin
            for (int i = 0; i < N; i++)
                if (is_dead[i]) exp_ready[i] = 1'b1;
            if (can_load) begin
                for (int k = 0; k < N; k++) begin
                    int i;
                    i = (m_ptr + k) % N;
                    if (g < 0 && req_valid[i] && !is_dead[i]) begin
                        g = i;
                        exp_ready[i] = 1'b1;
                    end
                end
            end
        end
        exp_w = m_v && !(flush && m_spec);

        @(negedge CLK);
        checks++;
        if (req_ready !== exp_ready) begin
            failures++;
            $display("FAIL model_ready @%0t: got %b expected %b", $time, req_ready, exp_ready);
        end
        checks++;
        if (wb_write !== exp_w) begin
            failures++;
            $display("FAIL model_wb_write @%0t: got %b expected %b", $time, wb_write, exp_w);
        end
        checks++;
        if ({wb_sel, wb_tag, wb_data, wb_spec} !== {m_sel, m_tag, m_data, m_spec}) begin
            failures++;
            $display("FAIL model_wb_entry @%0t: got sel=%0d tag=%0d data=%h spec=%b expected sel=%0d tag=%0d data=%h spec=%b",
                     $time, wb_sel, wb_tag, wb_data, wb_spec, m_sel, m_tag, m_data, m_spec);
        end

        @(posedge CLK);
        if (RST) begin
            model_reset();
        end else begin
            if (g >= 0) begin
                m_v = 1; m_sel = sel[g]; m_tag = tag[g]; m_data = data[g];
                m_spec = req_spec[g] && !resolved;
                m_ptr = (g + 1) % N;
            end else if (can_load) begin
                m_v = 0;
            end else if (flush && m_spec) begin
                m_v = 0;
            end else if (resolved) begin
                m_spec = 0;
            end
            last_ready = exp_ready;
        end
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        RST = 1;
        @(posedge CLK);
        #1;
        model_reset();
        req_valid[0] = 1; sel[0] = 5'd3;
        #1;
        checks++;
        if (req_ready !== '0) begin
            failures++;
            $display("FAIL reset_ready: got %b expected 0000", req_ready);
        end
        cycle();
        RST = 0;
        clear_inputs();
        #1;
        checks++;
        if ({wb_write, wb_sel, wb_tag, wb_data, wb_spec} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got write=%b sel=%0d tag=%0d data=%h spec=%b expected all 0",
                     wb_write, wb_sel, wb_tag, wb_data, wb_spec);
        end
        cycle();
    endtask

    task automatic test_basic();
        req_valid[0] = 1; sel[0] = 5'd7; tag[0] = 3'd2; data[0] = 32'hDEADBEEF;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL basic_ready: got %b expected 0001", req_ready);
        end
        cycle();
        req_valid[0] = 0;
        #1;
        checks++;
        if ({wb_write, wb_sel, wb_tag, wb_data} !== {1'b1, 5'd7, 3'd2, 32'hDEADBEEF}) begin
            failures++;
            $display("FAIL basic_entry: got write=%b sel=%0d tag=%0d data=%h expected 1/7/2/deadbeef",
                     wb_write, wb_sel, wb_tag, wb_data);
        end
        // Pointer now 1: requester 1 beats requester 0.
        req_valid[0] = 1; sel[0] = 5'd8;
        req_valid[1] = 1; sel[1] = 5'd9;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL basic_ptr: got %b expected 0010", req_ready);
        end
        cycle();
        clear_inputs();
        cycle();
    endtask

    task automatic test_fairness();
        RST = 1; cycle(); RST = 0;
        for (int i = 0; i < N; i++) begin
            req_valid[i] = 1; sel[i] = RW'(i + 1); tag[i] = TW'(i); data[i] = 32'h100 + i;
        end
        for (int c = 0; c < 5; c++) begin
            logic [N-1:0] want;
            want = '0;
            want[c % N] = 1'b1;
            #1;
            checks++;
            if (req_ready !== want) begin
                failures++;
                $display("FAIL fair_grant%0d: got %b expected %b", c, req_ready, want);
            end
            if (c > 0) begin
                checks++;
                if (wb_write !== 1'b1) begin
                    failures++;
                    $display("FAIL fair_write%0d: got %b expected 1", c, wb_write);
                end
            end
            cycle();
            data[c % N] = data[c % N] + 32'h10;
        end
        clear_inputs();
        cycle();
    endtask

    task automatic test_stall();
        RST = 1; cycle(); RST = 0;
        req_valid[0] = 1; sel[0] = 5'd3; tag[0] = 3'd1; data[0] = 32'hA5A5_0000;
        cycle();
        req_valid[0] = 0;
        req_valid[1] = 1; sel[1] = 5'd12; tag[1] = 3'd6; data[1] = 32'h1234_5678;
        wb_stall = 1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (req_ready[1] !== 1'b0 || wb_sel !== 5'd3 || wb_data !== 32'hA5A5_0000) begin
                failures++;
                $display("FAIL stall_hold%0d: got ready1=%b sel=%0d data=%h expected 0/3/a5a50000",
                         c, req_ready[1], wb_sel, wb_data);
            end
            cycle();
        end
        wb_stall = 0;
        #1;
        checks++;
        if (req_ready[1] !== 1'b1) begin
            failures++;
            $display("FAIL stall_release: got ready1=%b expected 1", req_ready[1]);
        end
        cycle();
        req_valid[1] = 0;
        #1;
        checks++;
        if ({wb_write, wb_sel, wb_data} !== {1'b1, 5'd12, 32'h1234_5678}) begin
            failures++;
            $display("FAIL stall_after: got write=%b sel=%0d data=%h expected 1/12/12345678",
                     wb_write, wb_sel, wb_data);
        end
        cycle();
    endtask

    task automatic test_flush();
        RST = 1; cycle(); RST = 0;
        req_valid[0] = 1; req_spec[0] = 1; sel[0] = 5'd4; data[0] = 32'h4444;
        cycle();
        req_valid[0] = 0; req_spec[0] = 0;
        wb_stall = 1;
        req_valid[2] = 1; req_spec[2] = 1; sel[2] = 5'd5; data[2] = 32'h5555;
        req_valid[3] = 1; req_spec[3] = 0; sel[3] = 5'd6; data[3] = 32'h6666;
        flush = 1;
        #1;
        checks++;
        if (wb_write !== 1'b0 || req_ready !== 4'b0100) begin
            failures++;
            $display("FAIL flush_cycle: got write=%b ready=%b expected 0/0100", wb_write, req_ready);
        end
        cycle();
        flush = 0; req_valid[2] = 0; req_spec[2] = 0;
        #1;
        checks++;
        if (wb_write !== 1'b0 || req_ready !== 4'b1000) begin
            failures++;
            $display("FAIL flush_next: got write=%b ready=%b expected 0/1000", wb_write, req_ready);
        end
        cycle();
        req_valid[3] = 0;
        #1;
        checks++;
        if ({wb_write, wb_sel, wb_data, wb_spec} !== {1'b1, 5'd6, 32'h6666, 1'b0}) begin
            failures++;
            $display("FAIL flush_req3: got write=%b sel=%0d data=%h spec=%b expected 1/6/6666/0",
                     wb_write, wb_sel, wb_data, wb_spec);
        end
        cycle();
        wb_stall = 0;
        cycle();
    endtask

    task automatic test_resolved_r0();
        RST = 1; cycle(); RST = 0;
        req_valid[1] = 1; req_spec[1] = 1; sel[1] = 5'd9; data[1] = 32'h9999;
        cycle();
        req_valid[1] = 0; req_spec[1] = 0;
        wb_stall = 1; resolved = 1;
        cycle();
        resolved = 0;
        #1;
        checks++;
        if (wb_spec !== 1'b0) begin
            failures++;
            $display("FAIL resolved_spec: got %b expected 0", wb_spec);
        end
        flush = 1;
        #1;
        checks++;
        if (wb_write !== 1'b1) begin
            failures++;
            $display("FAIL resolved_flush_mask: got %b expected 1", wb_write);
        end
        cycle();
        flush = 0;
        // r0 destination under stall: acknowledged, never written back.
        req_valid[2] = 1; sel[2] = 5'd0; data[2] = 32'h0BAD;
        #1;
        checks++;
        if (wb_write !== 1'b1 || req_ready !== 4'b0100) begin
            failures++;
            $display("FAIL r0_accept: got write=%b ready=%b expected 1/0100", wb_write, req_ready);
        end
        cycle();
        req_valid[2] = 0;
        wb_stall = 0;
        cycle();
        #1;
        checks++;
        if (wb_write !== 1'b0 || wb_sel !== 5'd9) begin
            failures++;
            $display("FAIL r0_no_write: got write=%b sel=%0d expected 0/9", wb_write, wb_sel);
        end
        cycle();
    endtask

    task automatic test_reset_mid_stall();
        req_valid[3] = 1; sel[3] = 5'd17; tag[3] = 3'd5; data[3] = 32'hCAFE;
        cycle();
        req_valid[3] = 0;
        wb_stall = 1;
        req_valid[0] = 1; sel[0] = 5'd1;
        RST = 1;
        #1;
        checks++;
        if (req_ready !== '0) begin
            failures++;
            $display("FAIL rst_ready: got %b expected 0000", req_ready);
        end
        cycle();
        RST = 0;
        req_valid[1] = 1; sel[1] = 5'd2;
        #1;
        checks++;
        if ({wb_write, wb_sel, wb_tag, wb_data, wb_spec} !== '0 || req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL rst_mid_stall: got write=%b sel=%0d tag=%0d data=%h spec=%b ready=%b expected zeros/0001",
                     wb_write, wb_sel, wb_tag, wb_data, wb_spec, req_ready);
        end
        cycle();
        clear_inputs();
        cycle();
    endtask

    task automatic test_random();
        RST = 1; cycle(); RST = 0;
        clear_inputs();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && last_ready[i]) req_valid[i] = 0;
                if (!req_valid[i] && $urandom_range(0, 99) < 60) begin
                    req_valid[i] = 1;
                    sel[i]       = ($urandom_range(0, 7) == 0) ? '0 : RW'($urandom);
                    tag[i]       = TW'($urandom);
                    data[i]      = $urandom;
                    req_spec[i]  = ($urandom_range(0, 2) == 0);
                end
            end
            wb_stall = ($urandom_range(0, 99) < 35);
            flush    = ($urandom_range(0, 99) < 10);
            resolved = ($urandom_range(0, 99) < 15);
            RST      = ($urandom_range(0, 99) < 2);
            cycle();
        end
        RST = 0;
        clear_inputs();
        cycle();
    endtask

    initial begin
        clear_inputs();
        model_reset();
        RST = 1;
        test_reset();
        test_basic();
        test_fairness();
        test_stall();
        test_flush();
        test_resolved_r0();
        test_reset_mid_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
